// File: rtl/l2tlb_arbiter.sv
// l2tlb_arbiter: shares one L2 TLB request port between the ITLB and DTLB, one transaction at a time.
// Optional L2TLB_ARB_RR_EN selects round-robin arbitration instead of fixed DTLB priority.
module l2tlb_arbiter #(
    parameter int ADDR_W = 27,
    parameter int PPN_W  = 38
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_i_req_valid,
    output logic              io_i_req_ready,
    input  logic [1:0]        io_i_req_bits_prv,
    input  logic              io_i_req_bits_pum,
    input  logic              io_i_req_bits_mxr,
    input  logic              io_i_req_bits_store,
    input  logic              io_i_req_bits_fetch,
    input  logic [ADDR_W-1:0] io_i_req_bits_addr,
    output logic              io_i_resp_valid,
    output logic [PPN_W-1:0]  io_i_resp_bits_pte_ppn,
    output logic              io_i_resp_bits_pte_d,
    output logic              io_i_resp_bits_pte_a,
    output logic              io_i_resp_bits_pte_g,
    output logic              io_i_resp_bits_pte_u,
    output logic              io_i_resp_bits_pte_x,
    output logic              io_i_resp_bits_pte_w,
    output logic              io_i_resp_bits_pte_r,
    output logic              io_i_resp_bits_pte_v,
    input  logic              io_d_req_valid,
    output logic              io_d_req_ready,
    input  logic [1:0]        io_d_req_bits_prv,
    input  logic              io_d_req_bits_pum,
    input  logic              io_d_req_bits_mxr,
    input  logic              io_d_req_bits_store,
    input  logic              io_d_req_bits_fetch,
    input  logic [ADDR_W-1:0] io_d_req_bits_addr,
    output logic              io_d_resp_valid,
    output logic [PPN_W-1:0]  io_d_resp_bits_pte_ppn,
    output logic              io_d_resp_bits_pte_d,
    output logic              io_d_resp_bits_pte_a,
    output logic              io_d_resp_bits_pte_g,
    output logic              io_d_resp_bits_pte_u,
    output logic              io_d_resp_bits_pte_x,
    output logic              io_d_resp_bits_pte_w,
    output logic              io_d_resp_bits_pte_r,
    output logic              io_d_resp_bits_pte_v,
    output logic              io_l2_req_valid,
    input  logic              io_l2_req_ready,
    output logic [1:0]        io_l2_req_bits_prv,
    output logic              io_l2_req_bits_pum,
    output logic              io_l2_req_bits_mxr,
    output logic [ADDR_W-1:0] io_l2_req_bits_addr,
    output logic              io_l2_req_bits_store,
    output logic              io_l2_req_bits_fetch,
    input  logic              io_l2_resp_valid,
    input  logic [PPN_W-1:0]  io_l2_resp_bits_pte_ppn,
    input  logic              io_l2_resp_bits_pte_d,
    input  logic              io_l2_resp_bits_pte_a,
    input  logic              io_l2_resp_bits_pte_g,
    input  logic              io_l2_resp_bits_pte_u,
    input  logic              io_l2_resp_bits_pte_x,
    input  logic              io_l2_resp_bits_pte_w,
    input  logic              io_l2_resp_bits_pte_r,
    input  logic              io_l2_resp_bits_pte_v,
    input  logic              io_ptw_invalidate
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    localparam int REQ_W = ADDR_W + 6;

    state_t           state_q, state_d;
    logic [REQ_W-1:0] req_q, req_d, i_bits, d_bits;
    logic             owner_q, owner_d, kill_q, kill_d;
    logic             pref_d, sel_d, fire, resp_fire;
    logic [7:0]       flags;
    logic [PPN_W-1:0] ppn;

    assign i_bits = {io_i_req_bits_prv, io_i_req_bits_pum, io_i_req_bits_mxr,
                     io_i_req_bits_store, io_i_req_bits_fetch, io_i_req_bits_addr};
    assign d_bits = {io_d_req_bits_prv, io_d_req_bits_pum, io_d_req_bits_mxr,
                     io_d_req_bits_store, io_d_req_bits_fetch, io_d_req_bits_addr};

`ifdef L2TLB_ARB_RR_EN
    logic last_q, last_d;
    assign pref_d = !last_q;
    assign last_d = fire ? sel_d : last_q;
    always_ff @(posedge clock) begin
        if (reset) last_q <= 1'b0;
        else       last_q <= last_d;
    end
`else
    assign pref_d = 1'b1;
`endif

    assign sel_d     = io_d_req_valid && (!io_i_req_valid || pref_d);
    assign fire      = (state_q == IDLE) && !reset && (io_i_req_valid || io_d_req_valid);
    assign resp_fire = (state_q == WAIT) && !reset && io_l2_resp_valid;

    assign io_i_req_ready = (state_q == IDLE) && !reset && io_i_req_valid && !sel_d;
    assign io_d_req_ready = (state_q == IDLE) && !reset && sel_d;
    assign io_l2_req_valid = (state_q == SEND) && !reset;
    assign {io_l2_req_bits_prv, io_l2_req_bits_pum, io_l2_req_bits_mxr,
            io_l2_req_bits_store, io_l2_req_bits_fetch, io_l2_req_bits_addr} = reset ? '0 : req_q;

    // Response payload goes to both sides; only the owner sees valid. Kill squashes pte_v.
    assign ppn   = reset ? '0 : io_l2_resp_bits_pte_ppn;
    assign flags = reset ? '0 : {io_l2_resp_bits_pte_d, io_l2_resp_bits_pte_a, io_l2_resp_bits_pte_g,
                                 io_l2_resp_bits_pte_u, io_l2_resp_bits_pte_x, io_l2_resp_bits_pte_w,
                                 io_l2_resp_bits_pte_r, io_l2_resp_bits_pte_v && !kill_q};
    assign io_i_resp_valid        = resp_fire && !owner_q;
    assign io_d_resp_valid        = resp_fire && owner_q;
    assign io_i_resp_bits_pte_ppn = ppn;
    assign io_d_resp_bits_pte_ppn = ppn;
    assign {io_i_resp_bits_pte_d, io_i_resp_bits_pte_a, io_i_resp_bits_pte_g, io_i_resp_bits_pte_u,
            io_i_resp_bits_pte_x, io_i_resp_bits_pte_w, io_i_resp_bits_pte_r, io_i_resp_bits_pte_v} = flags;
    assign {io_d_resp_bits_pte_d, io_d_resp_bits_pte_a, io_d_resp_bits_pte_g, io_d_resp_bits_pte_u,
            io_d_resp_bits_pte_x, io_d_resp_bits_pte_w, io_d_resp_bits_pte_r, io_d_resp_bits_pte_v} = flags;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        kill_d  = kill_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = SEND;
                    req_d   = sel_d ? d_bits : i_bits;
                    owner_d = sel_d;
                    kill_d  = 1'b0;
                end
            end
            SEND: begin
                kill_d = kill_q || io_ptw_invalidate;
                if (io_l2_req_ready) state_d = WAIT;
            end
            WAIT: begin
                kill_d = kill_q || io_ptw_invalidate;
                if (resp_fire) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
        end
    end
endmodule
